// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, select struct and decode helpers for the logic-unit issue stage
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    typedef struct packed {
        logic sel_and;
        logic sel_or;
        logic sel_xor;
        logic sel_inv;
    } logic_sel_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

    function automatic logic_sel_t decode_op(input logic [2:0] op);
        logic_sel_t sel;
        sel = '0;
        case (op)
            OP_AND:  sel.sel_and = 1'b1;
            OP_OR:   sel.sel_or  = 1'b1;
            OP_XOR:  sel.sel_xor = 1'b1;
            OP_NAND: begin sel.sel_and = 1'b1; sel.sel_inv = 1'b1; end
            OP_NOR:  begin sel.sel_or  = 1'b1; sel.sel_inv = 1'b1; end
            OP_XNOR: begin sel.sel_xor = 1'b1; sel.sel_inv = 1'b1; end
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// rtl/alu_skid_buf.sv - two-entry skid buffer (main M + skid S) with registered in_ready and out_valid
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int PW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    buf_state_t    state_q, state_d;
    logic [PW-1:0] m_q, m_d;
    logic [PW-1:0] s_q, s_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          push;

    assign push = in_valid & ready_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    m_d     = in_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (out_ready) begin
                    if (push) m_d = in_data;
                    else      state_d = BUF_EMPTY;
                end else if (push) begin
                    s_d     = in_data;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // in_ready is low here, so nothing new can arrive while S drains into M
                if (out_ready) begin
                    m_d     = s_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        ready_d = (state_d != BUF_FULL);
        valid_d = (state_d != BUF_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = m_q;

endmodule

// File: rtl/alu_logic_issue.sv
// rtl/alu_logic_issue.sv - issue stage: opcode decode, illegal-op rejection and skid-buffered issue to the logic unit
module alu_logic_issue
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 c_and,
    output logic                 c_or,
    output logic                 c_xor,
    output logic                 c_inv,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 op_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PW = $bits(logic_sel_t) + 2 * WIDTH;

    logic                 accept;
    logic                 legal;
    logic                 op_err_q, op_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [PW-1:0]        in_payload;
    logic [PW-1:0]        out_payload;
    logic_sel_t           m_sel;

    assign accept = in_valid & in_ready;
    assign legal  = is_legal_op(in_op);

    // Payload carries the decoded selects, so downstream never sees a raw opcode
    assign in_payload = {decode_op(in_op), in_a, in_b};

    alu_skid_buf #(
        .PW(PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & legal),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {m_sel, a, b} = out_payload;

    assign c_and = out_valid & m_sel.sel_and;
    assign c_or  = out_valid & m_sel.sel_or;
    assign c_xor = out_valid & m_sel.sel_xor;
    assign c_inv = out_valid & m_sel.sel_inv;

    always_comb begin
        op_err_d  = accept & ~legal;
        err_cnt_d = err_cnt_q;
        if (op_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            op_err_q  <= op_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_err  = op_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_alu_logic_issue.sv
// tb/tb_alu_logic_issue.sv - randomized and directed bench for alu_logic_issue against a queue model
module tb_alu_logic_issue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       c_and, c_or, c_xor, c_inv;
    logic [7:0] a, b;
    logic       op_err;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_logic_issue #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .c_and(c_and), .c_or(c_or), .c_xor(c_xor), .c_inv(c_inv),
        .a(a), .b(b), .op_err(op_err), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
    } item_t;

    item_t q[$];
    item_t last_item;
    bit    exp_err;
    int    exp_cnt;

    function automatic logic [3:0] sel_of(input logic [2:0] op);
        case (op)
            3'd0: return 4'b1000;
            3'd1: return 4'b0100;
            3'd2: return 4'b0010;
            3'd3: return 4'b1001;
            3'd4: return 4'b0101;
            3'd5: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted-but-unconsumed requests
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                last_item = '{sel: 4'd0, a: 8'd0, b: 8'd0};
                exp_err = 0;
                exp_cnt = 0;
            end else begin
                bit acc, lgl, pop;
                acc = in_valid && (q.size() < 2);
                lgl = (in_op < 3'd6);
                pop = out_ready && (q.size() > 0);
                if (pop) last_item = q.pop_front();
                exp_err = acc && !lgl;
                if (exp_err && exp_cnt < 255) exp_cnt++;
                if (acc && lgl) q.push_back('{sel: sel_of(in_op), a: in_a, b: in_b});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                item_t cur;
                cur = (q.size() > 0) ? q[0] : last_item;
                check("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
                check("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
                check("m_sel", {28'd0, c_and, c_or, c_xor, c_inv},
                      {28'd0, (q.size() > 0) ? cur.sel : 4'd0});
                check("m_a", {24'd0, a}, {24'd0, cur.a});
                check("m_b", {24'd0, b}, {24'd0, cur.b});
                check("m_op_err", {31'd0, op_err}, {31'd0, exp_err});
                check("m_err_cnt", {24'd0, err_cnt}, exp_cnt);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] da, input logic [7:0] db);
        in_valid = v;
        in_op    = op;
        in_a     = da;
        in_b     = db;
    endtask

    logic [2:0] stream_ops [5];
    logic [3:0] stream_sel [5];

    initial begin
        stream_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        stream_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0101, 4'b0011};

        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_err_cnt", {24'd0, err_cnt}, 0);
        rst_n = 1'b1;

        // single NAND
        @(negedge clk);
        drive(1, 3'b011, 8'hF0, 8'h3C);
        @(negedge clk);
        check("nand_valid", {31'd0, out_valid}, 1);
        check("nand_sel", {28'd0, c_and, c_or, c_xor, c_inv}, 32'h9);
        check("nand_a", {24'd0, a}, 32'hF0);
        check("nand_b", {24'd0, b}, 32'h3C);
        drive(0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("nand_drop", {31'd0, out_valid}, 0);
        check("nand_sel0", {28'd0, c_and, c_or, c_xor, c_inv}, 0);

        // back-to-back stream
        for (int i = 0; i < 5; i++) begin
            drive(1, stream_ops[i], 8'(i + 1), 8'(i + 16));
            @(negedge clk);
            check("stream_sel", {28'd0, c_and, c_or, c_xor, c_inv}, {28'd0, stream_sel[i]});
            check("stream_ready", {31'd0, in_ready}, 1);
        end
        drive(0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);

        // stall fills skid, drain in order
        out_ready = 1'b0;
        drive(1, 3'd0, 8'h11, 8'h22);
        @(negedge clk);
        check("stall_ready1", {31'd0, in_ready}, 1);
        drive(1, 3'd2, 8'h33, 8'h44);
        @(negedge clk);
        check("stall_full", {31'd0, in_ready}, 0);
        check("stall_hold_a", {24'd0, a}, 32'h11);
        drive(0, 3'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_second", {24'd0, a}, 32'h33);
        check("drain_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        check("drain_empty", {31'd0, out_valid}, 0);

        // illegal opcodes
        drive(1, 3'b110, 8'h55, 8'h66);
        @(negedge clk);
        check("ill1_err", {31'd0, op_err}, 1);
        drive(1, 3'b111, 8'h55, 8'h66);
        @(negedge clk);
        check("ill2_err", {31'd0, op_err}, 1);
        check("ill2_cnt", {24'd0, err_cnt}, 2);
        check("ill2_novalid", {31'd0, out_valid}, 0);
        drive(0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("ill_pulse_end", {31'd0, op_err}, 0);

        // illegal while ONE and stalled must not fill skid
        out_ready = 1'b0;
        drive(1, 3'd1, 8'hA5, 8'h5A);
        @(negedge clk);
        drive(1, 3'b110, 8'h00, 8'h00);
        @(negedge clk);
        check("one_ill_ready", {31'd0, in_ready}, 1);
        check("one_ill_err", {31'd0, op_err}, 1);
        check("one_ill_cnt", {24'd0, err_cnt}, 3);
        drive(0, 3'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("one_ill_noskid", {31'd0, out_valid}, 0);

        // saturation
        for (int i = 0; i < 260; i++) begin
            drive(1, 3'b111, 8'(i), 8'(i));
            @(negedge clk);
        end
        drive(0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("sat_cnt", {24'd0, err_cnt}, 32'hFF);
        drive(1, 3'b110, 8'd0, 8'd0);
        @(negedge clk);
        drive(0, 3'd0, 8'd0, 8'd0);
        check("sat_hold", {24'd0, err_cnt}, 32'hFF);
        check("sat_pulse", {31'd0, op_err}, 1);

        // reset while FULL
        out_ready = 1'b0;
        drive(1, 3'd3, 8'h77, 8'h88);
        @(negedge clk);
        drive(1, 3'd4, 8'h99, 8'hAA);
        @(negedge clk);
        drive(0, 3'd0, 8'd0, 8'd0);
        check("pre_rst_full", {31'd0, in_ready}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_ready", {31'd0, in_ready}, 1);
        check("arst_sel", {28'd0, c_and, c_or, c_xor, c_inv}, 0);
        check("arst_ab", {16'd0, a, b}, 0);
        check("arst_err", {23'd0, op_err, err_cnt}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_novalid", {31'd0, out_valid}, 0);
            check("post_rst_ready", {31'd0, in_ready}, 1);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom));
            if (i % 400 < 40) out_ready = ($urandom_range(0, 7) == 0);
            else              out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        drive(0, 3'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_logic_issue.md
Name: alu_logic_issue

Overview:
- Issue stage directly upstream of the inverting logic unit: accepts {opcode, operand A, operand B} under a valid/ready handshake.
- Decodes the 3-bit opcode into the unit's one-hot function selects c_and/c_or/c_xor plus c_inv.
- Presents registered operands and selects through a 2-entry skid buffer, so in_ready is a pure register output and backpressure never drops a transfer.
- Rejects illegal opcodes with an error pulse and a saturating reject counter.

Parameters:
- WIDTH, 8, operand width in bits; must match the logic unit's WIDTH.
- ERR_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  stage can accept; registered.
- in_op  input  3  opcode (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  selects and operands below are valid.
- out_ready  input  1  downstream (logic unit result register) accepts.
- c_and  output  1  AND select to logic unit.
- c_or  output  1  OR select to logic unit.
- c_xor  output  1  XOR select to logic unit.
- c_inv  output  1  output-invert select to logic unit.
- a  output  WIDTH  operand A to logic unit.
- b  output  WIDTH  operand B to logic unit.
- op_err  output  1  one-cycle pulse on an accepted illegal opcode.
- err_cnt  output  ERR_CNT_W  count of illegal opcodes; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, all selects=0, a=b=0, op_err=0, err_cnt=0, skid entry empty.
- Opcode map: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - Exactly one of c_and/c_or/c_xor is 1; c_inv=1 for 011..101.
  - 110 and 111 are illegal.
- Accept condition: in_valid & in_ready.
  - Legal op: decode at accept; store {sel, a, b} decoded, not raw op.
  - Illegal op: consumed (in_ready handshake completes), never forwarded.
  - op_err=1 on the next cycle; err_cnt increments by 1 unless all-ones.
- Storage: main register M (drives outputs) and skid register S. States by occupancy:
  - EMPTY: M invalid, S invalid, in_ready=1.
    - Legal accept -> ONE; M loads the request; out_valid=1 next cycle. Latency 1 cycle.
  - ONE: M valid, S invalid, in_ready=1.
    - out_ready=1, legal accept: M reloads with the new request; stay ONE. Back-to-back throughput 1/cycle.
    - out_ready=1, no legal accept -> EMPTY.
    - out_ready=0, legal accept: request goes to S -> FULL.
    - out_ready=0, no accept: hold.
  - FULL: M valid, S valid, in_ready=0.
    - out_ready=1: M<=S, S cleared -> ONE; in_ready=1 next cycle.
    - out_ready=0: hold.
- in_ready next = !(next state == FULL).
- Illegal accept in ONE with out_ready=0 does not fill S.
- Output rules:
  - a, b and the selects reflect M only.
  - When out_valid=0 all selects are forced to 0; a/b hold their last value.
  - Outputs are stable while out_valid & !out_ready (no change until handshake).
- Ordering: strict FIFO; S contents always issue after M.
- Reset mid-operation discards both entries without emitting op_err.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package alu_pkg holds:
  - OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NAND=3'b011, OP_NOR=3'b100, OP_XNOR=3'b101.
  - A packed logic_sel_t {and, or, xor, inv}.
  - An is_legal_op function.
- One natural sub-module: alu_skid_buf, parameterised on payload width (4 + 2*WIDTH), containing M/S registers and in_ready/out_valid logic.
- Decode and error counting stay in alu_logic_issue.

Test Plan:
- Reset then single op=011, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_valid=1, c_and=1, c_inv=1, a=F0, b=3C; following cycle out_valid=0, selects 0.
- Stream ops 000,001,010,100,101 on consecutive cycles, out_ready=1 -> five consecutive out_valid cycles with correct one-hot and c_inv, in_ready never drops.
- Hold out_ready=0, send two legal ops -> in_ready=0 after the second; raise out_ready -> both issue in order on two consecutive cycles, in_ready=1 one cycle after the first drain.
- op=110 then op=111 -> no out_valid, op_err pulses twice, err_cnt=2; preload 255 illegal ops then one more -> err_cnt stays 8'hFF.
- Assert rst_n=0 while FULL -> outputs immediately at reset values; after release, in_ready=1 and no stale transfer appears.
- Illegal op accepted while ONE with out_ready=0 -> S stays empty, in_ready stays 1, op_err=1.
